// File: rtl/project1_pkg.sv
// project1_pkg
//   Shared types and constants for the operand framer slice.
//   - framer_state_e : how many bit pairs the framer currently holds
//                      (EMPTY = none, HALF = one, FULL = frame presented)
//   - DEFAULT_CNT_W  : default width of the statistics counters
package project1_pkg;

    localparam int DEFAULT_CNT_W = 8;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } framer_state_e;

endpackage

// File: rtl/project1_sat_cnt.sv
// project1_sat_cnt
//   Up-counter that sticks at its all-ones maximum instead of wrapping.
//   A clear always wins over an increment in the same cycle.
//   Ports:
//     clk  - rising-edge clock
//     rst  - asynchronous active-high reset (q -> 0)
//     clr  - synchronous clear (q -> 0 next cycle)
//     inc  - add one this cycle unless already at maximum
//     q    - current count, W bits
module project1_sat_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != {W{1'b1}})) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/project1_operand_framer.sv
// project1_operand_framer
//   Collects two serial (x, y) bit pairs into one operand frame
//   {x1, x2, y1, y2} for the minterm-OR evaluator, presents it with a
//   valid/ready handshake, registers the evaluator's answer b and keeps
//   saturating frame / hit statistics.
//
//   Handshakes (both sides):
//     A transfer happens on a rising clk edge where valid and ready are both
//     high. The source keeps its data stable while valid is high and ready
//     is low. sin_ready = (state != FULL) | op_ready, so a new pair may be
//     accepted in the very cycle the presented frame is consumed.
//
//   Optional build macro: PROJECT1_FRAMER_OVERRUN_EN adds the sticky
//   'overrun' output (set on sin_valid & ~sin_ready, cleared by clr_cnt,
//   set wins over clear).
//
//   Ports:
//     clk, rst             - clock, asynchronous active-high reset
//     sin_valid/sin_ready  - serial bit-pair handshake
//     sin_x, sin_y         - serial operand bits
//     x1, x2, y1, y2       - frame bits (first / second captured)
//     op_valid/op_ready    - frame handshake towards the evaluator
//     b_in                 - evaluator result, sampled only on consume
//     res_valid, res_b     - one-cycle pulse with the registered result
//     frame_cnt, hit_cnt   - saturating statistics
//     overrun              - (optional) sticky upstream overrun flag
//     clr_cnt              - synchronous clear of statistics (and overrun)
//     state                - debug view of the framer FSM
module project1_operand_framer
    import project1_pkg::*;
#(
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sin_valid,
    output logic             sin_ready,
    input  logic             sin_x,
    input  logic             sin_y,
    output logic             x1,
    output logic             x2,
    output logic             y1,
    output logic             y2,
    output logic             op_valid,
    input  logic             op_ready,
    input  logic             b_in,
    output logic             res_valid,
    output logic             res_b,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] hit_cnt,
`ifdef PROJECT1_FRAMER_OVERRUN_EN
    output logic             overrun,
`endif
    input  logic             clr_cnt,
    output framer_state_e    state
);

    framer_state_e state_q;
    framer_state_e state_d;
    logic          accept;
    logic          consume;

    assign sin_ready = (state_q != FULL) | op_ready;
    assign op_valid  = (state_q == FULL);
    assign accept    = sin_valid & sin_ready;
    assign consume   = (state_q == FULL) & op_ready;
    assign state     = state_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: if (accept) state_d = HALF;
            HALF:  if (accept) state_d = FULL;
            FULL: begin
                // A pair arriving with the consume starts the next frame.
                if (consume) state_d = accept ? HALF : EMPTY;
            end
            default: state_d = EMPTY;
        endcase
    end

    // Frame bits. x2/y2 are left stale outside FULL; op_valid qualifies them.
    // An accept while FULL only happens together with a consume, so it
    // loads the first bit of the next frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x1 <= 1'b0;
            y1 <= 1'b0;
            x2 <= 1'b0;
            y2 <= 1'b0;
        end else if (accept) begin
            if (state_q == HALF) begin
                x2 <= sin_x;
                y2 <= sin_y;
            end else begin
                x1 <= sin_x;
                y1 <= sin_y;
            end
        end
    end

    // Result capture is independent of clr_cnt.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_valid <= 1'b0;
            res_b     <= 1'b0;
        end else begin
            res_valid <= consume;
            if (consume) res_b <= b_in;
        end
    end

    project1_sat_cnt #(.W(CNT_W)) u_frame_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clr_cnt),
        .inc (consume),
        .q   (frame_cnt)
    );

    project1_sat_cnt #(.W(CNT_W)) u_hit_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clr_cnt),
        .inc (consume & b_in),
        .q   (hit_cnt)
    );

`ifdef PROJECT1_FRAMER_OVERRUN_EN
    // A new overrun in the clearing cycle must not be lost, so set wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun <= 1'b0;
        end else if (sin_valid & ~sin_ready) begin
            overrun <= 1'b1;
        end else if (clr_cnt) begin
            overrun <= 1'b0;
        end
    end
`endif

endmodule
